// File: rtl/passcode_pkg.sv
// ---------------------------------------------------------------------------
// passcode_pkg : state encodings and defaults shared by the passcode FSM/timer
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package passcode_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DIG1CORR = 3'd1,
      S_DIG2CORR = 3'd2,
      S_DIG3CORR = 3'd3,
      S_DIG4CORR = 3'd4
   } passcode_state_e;

   localparam int CLK_HZ_DEFAULT    = 50_000_000;
   localparam int TIMEOUT_S_DEFAULT = 20;

   // Seconds never exceed 99, so seven bits hold every legal value.
   localparam int SEC_W = 7;

   function automatic logic is_counting_state(input logic [2:0] state);
      return (state == S_DIG1CORR) || (state == S_DIG2CORR) || (state == S_DIG3CORR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen : prescaler producing a one-cycle tick every CLK_HZ enabled cycles
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_gen
   import passcode_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int               CNT_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] r_cnt;

   // Clear dominates so a reload never coincides with a decrement.
   assign tick = enable && !clear && (r_cnt == c_last_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear || tick) begin
         r_cnt <= '0;
      end else if (enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/entry_timer.sv
// ---------------------------------------------------------------------------
// entry_timer : per-digit countdown with timeout pulse and BCD display digits
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module entry_timer
   import passcode_pkg::*;
#(
   parameter int CLK_HZ    = CLK_HZ_DEFAULT,
   parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  passcode_state,
   output logic [31:0] timer,
   output logic        timeout,
   output logic        running,
   output logic [3:0]  bcd_tens,
   output logic [3:0]  bcd_ones
);

   localparam logic [SEC_W-1:0] c_reload   = SEC_W'(TIMEOUT_S);
   localparam logic [3:0]       c_rst_tens = 4'(TIMEOUT_S / 10);
   localparam logic [3:0]       c_rst_ones = 4'(TIMEOUT_S % 10);

   logic [2:0]       r_prev_state;
   logic [SEC_W-1:0] r_timer;
   logic             r_timeout;
   logic [3:0]       r_bcd_tens;
   logic [3:0]       r_bcd_ones;

   logic             w_changed;
   logic             w_counting;
   logic             w_reload;
   logic             w_enable;
   logic             w_tick;
   logic [SEC_W-1:0] w_timer_nxt;

   assign w_changed  = (passcode_state != r_prev_state);
   assign w_counting = is_counting_state(passcode_state);
   assign w_reload   = w_changed || !w_counting;
   assign w_enable   = w_counting && (r_timer != '0);

   tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (w_reload),
      .enable (w_enable),
      .tick   (w_tick)
   );

   always_comb begin
      w_timer_nxt = r_timer;
      if (w_reload) begin
         w_timer_nxt = c_reload;
      end else if (w_tick) begin
         w_timer_nxt = r_timer - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_state <= S_IDLE;
         r_timer      <= c_reload;
         r_timeout    <= 1'b0;
         r_bcd_tens   <= c_rst_tens;
         r_bcd_ones   <= c_rst_ones;
      end else begin
         r_prev_state <= passcode_state;
         r_timer      <= w_timer_nxt;
         // Registered alongside the counter so the pulse lands on the timer==0 cycle.
         r_timeout    <= (r_timer == SEC_W'(1)) && (w_timer_nxt == '0);
         r_bcd_tens   <= 4'(r_timer / SEC_W'(10));
         r_bcd_ones   <= 4'(r_timer % SEC_W'(10));
      end
   end

   assign timer    = {{(32 - SEC_W){1'b0}}, r_timer};
   assign timeout  = r_timeout;
   assign running  = w_counting && (r_timer != '0) && !w_changed;
   assign bcd_tens = r_bcd_tens;
   assign bcd_ones = r_bcd_ones;

endmodule

`default_nettype wire

// File: tb/tb_entry_timer.sv
// ---------------------------------------------------------------------------
// tb_entry_timer : directed bench for entry_timer (CLK_HZ=10, TIMEOUT_S=3)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_entry_timer;
   import passcode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  drv_state = 3'd0;
   logic [2:0]  fsm_state;
   logic [2:0]  pstate;
   logic        use_fsm = 1'b0;
   logic        digit_ok = 1'b0;
   logic [31:0] timer;
   logic        timeout;
   logic        running;
   logic [3:0]  bcd_tens;
   logic [3:0]  bcd_ones;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;
   int p0       = 0;

   assign pstate = use_fsm ? fsm_state : drv_state;

   entry_timer #(
      .CLK_HZ    (10),
      .TIMEOUT_S (3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .passcode_state (pstate),
      .timer          (timer),
      .timeout        (timeout),
      .running        (running),
      .bcd_tens       (bcd_tens),
      .bcd_ones       (bcd_ones)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (timeout === 1'b1) n_pulses++;

   // Minimal passcode FSM: advances on a correct digit, falls back to idle on timeout.
   always @(posedge clk) begin
      if (!rst_n)                             fsm_state <= S_IDLE;
      else if (timeout)                       fsm_state <= S_IDLE;
      else if (digit_ok && fsm_state < 3'd4)  fsm_state <= fsm_state + 3'd1;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values
      rst_n = 1'b0; drv_state = 3'd0;
      cyc(3);
      chk("rst_timer",   timer,    32'd3);
      chk("rst_tens",    bcd_tens, 32'd0);
      chk("rst_ones",    bcd_ones, 32'd3);
      chk("rst_timeout", timeout,  32'd0);
      chk("rst_running", running,  32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Full countdown
      p0 = n_pulses;
      drv_state = 3'd1;
      #1 chk("fc_running_on_change", running, 32'd0);
      cyc(1);  chk("fc_reload", timer, 32'd3); chk("fc_running", running, 32'd1);
      cyc(9);  chk("fc_t10", timer, 32'd3);
      cyc(1);  chk("fc_t11", timer, 32'd2); chk("fc_bcd_lag", bcd_ones, 32'd3);
      cyc(1);  chk("fc_bcd_t12", bcd_ones, 32'd2);
      cyc(9);  chk("fc_t21", timer, 32'd1);
      cyc(10); chk("fc_t31", timer, 32'd0); chk("fc_timeout", timeout, 32'd1);
               chk("fc_running_exp", running, 32'd0); chk("fc_bcd_t31", bcd_ones, 32'd1);
      cyc(1);  chk("fc_timeout_drop", timeout, 32'd0); chk("fc_hold0", timer, 32'd0);
               chk("fc_bcd_zero", bcd_ones, 32'd0);
      cyc(20); chk("fc_hold0_late", timer, 32'd0); chk("fc_no_repulse", timeout, 32'd0);
      chk("fc_pulse_count", n_pulses - p0, 32'd1);

      // Reset mid-count
      drv_state = 3'd0; cyc(2);
      drv_state = 3'd1; cyc(15);
      chk("mc_pre", timer, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mc_async_timer", timer,    32'd3);
      chk("mc_async_tens",  bcd_tens, 32'd0);
      chk("mc_async_ones",  bcd_ones, 32'd3);
      chk("mc_async_to",    timeout,  32'd0);
      cyc(2);
      p0 = n_pulses;
      rst_n = 1'b1;
      cyc(1);  chk("mc_rel_t1", timer, 32'd3);
      cyc(9);  chk("mc_rel_t10", timer, 32'd3);
      cyc(1);  chk("mc_rel_t11", timer, 32'd2);
      chk("mc_no_pulse", n_pulses - p0, 32'd0);

      // Reload on next digit
      drv_state = 3'd0; cyc(2);
      p0 = n_pulses;
      drv_state = 3'd1; cyc(15);
      chk("rd_pre", timer, 32'd2);
      drv_state = 3'd2;
      cyc(1);  chk("rd_reload", timer, 32'd3);
      cyc(9);  chk("rd_t9", timer, 32'd3);
      cyc(1);  chk("rd_t10", timer, 32'd2);
      chk("rd_no_pulse", n_pulses - p0, 32'd0);

      // Holding states (unlocked and illegal)
      p0 = n_pulses;
      drv_state = 3'd4;
      cyc(25); chk("hold4_mid", timer, 32'd3); chk("hold4_run_mid", running, 32'd0);
      cyc(25); chk("hold4_end", timer, 32'd3); chk("hold4_run_end", running, 32'd0);
      drv_state = 3'd6;
      cyc(25); chk("hold6_mid", timer, 32'd3); chk("hold6_run_mid", running, 32'd0);
      cyc(25); chk("hold6_end", timer, 32'd3); chk("hold6_run_end", running, 32'd0);
      chk("hold_no_pulse", n_pulses - p0, 32'd0);

      // Collision: state change on the prescaler-wrap cycle
      drv_state = 3'd0; cyc(2);
      drv_state = 3'd1; cyc(10);
      chk("cw_pre", timer, 32'd3);
      drv_state = 3'd2;
      cyc(1);  chk("cw_no_dec", timer, 32'd3);
      cyc(9);  chk("cw_t10", timer, 32'd3);
      cyc(1);  chk("cw_t11", timer, 32'd2);

      // Collision: state change on the cycle timer reaches zero
      drv_state = 3'd0; cyc(2);
      p0 = n_pulses;
      drv_state = 3'd1; cyc(31);
      chk("cz_zero", timer, 32'd0); chk("cz_timeout", timeout, 32'd1);
      drv_state = 3'd2;
      #1 chk("cz_running", running, 32'd0);
      cyc(1);  chk("cz_reload", timer, 32'd3); chk("cz_timeout_drop", timeout, 32'd0);
      chk("cz_single_pulse", n_pulses - p0, 32'd1);

      // Closed loop with the FSM model
      drv_state = 3'd0; cyc(2);
      use_fsm = 1'b1;
      digit_ok = 1'b1;
      cyc(1);  digit_ok = 1'b0; chk("cl_state1", pstate, 32'd1);
      cyc(1);  chk("cl_reload", timer, 32'd3);
      cyc(30); chk("cl_zero", timer, 32'd0); chk("cl_timeout", timeout, 32'd1);
               chk("cl_state_still1", pstate, 32'd1);
      cyc(1);  chk("cl_idle", pstate, 32'd0); chk("cl_timer_still0", timer, 32'd0);
               chk("cl_timeout_drop", timeout, 32'd0);
      cyc(1);  chk("cl_reload_after_idle", timer, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/entry_timer.md
# entry_timer

Per-digit countdown timer that generates the `timer` seconds value consumed by the passcode FSM. It watches the FSM's `passcode_state` and reloads on every state change. While a digit entry is pending, it counts down one per second and holds at zero on expiry, so the FSM falls back to idle. It also drives a one-cycle timeout pulse and registered two-digit BCD for the seven-segment display.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; one second = `CLK_HZ` cycles (bench uses 10).
- `TIMEOUT_S`, 20: per-digit limit in seconds; legal range 1..99.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `passcode_state`  in  3: FSM state; 0 idle, 1/2/3 digits 1/2/3 correct, 4 unlocked.
- `timer`  out  32 (integer): seconds remaining.
- `timeout`  out  1: one-cycle pulse when `timer` reaches 0.
- `running`  out  1: high while counting down.
- `bcd_tens`  out  4: tens digit of `timer`.
- `bcd_ones`  out  4: ones digit of `timer`.

## Operation
- Internal `prev_state` register samples `passcode_state` every cycle. `changed = (passcode_state != prev_state)`.
- Counting states are 1, 2 and 3. Holding states are 0, 4 and any illegal value (5..7).
- Priority, evaluated every cycle, highest first:
  1. `changed`: `timer <= TIMEOUT_S`, prescaler cleared.
  2. Holding state: `timer <= TIMEOUT_S`, prescaler cleared.
  3. Counting state, `timer > 0`: prescaler increments. At `CLK_HZ-1` it wraps to 0 and `timer` decrements by 1.
  4. Counting state, `timer == 0`: `timer` and prescaler hold (expired). Only a state change leaves this.
- `timer` is never 0 except after expiry. A fresh entry state always sees a nonzero value.
- `timeout` = 1 for exactly the cycle in which registered `timer` goes 1 -> 0. It is not re-asserted while holding at 0.
- `running` = counting state AND `timer != 0` AND NOT `changed`.
- BCD: `bcd_tens = timer / 10` and `bcd_ones = timer % 10`, registered, valid for 0..99.
- Boundary cases:
  - `changed` on the same cycle as the prescaler wrap: reload wins, no decrement.
  - State change on the same cycle `timer` hits 0: reload wins. `timeout` still pulses, because it is defined on the registered transition.
  - Reset mid-count: immediate reload on deassertion, no pulse.

## Timing
- Reset values: `timer = TIMEOUT_S`, prescaler 0, `prev_state` 0, `timeout` 0, `running` 0, `bcd_tens`/`bcd_ones` = digits of `TIMEOUT_S`.
- Reload latency: `timer` shows `TIMEOUT_S` one cycle after `passcode_state` changes.
- First decrement: `CLK_HZ` cycles after entering a counting state. Subsequent decrements every `CLK_HZ` cycles.
- Full timeout: `TIMEOUT_S * CLK_HZ` cycles from state entry to `timer == 0`.
- `timeout` aligns with the `timer == 0` cycle. The FSM reaches idle one cycle later and the timer reloads one cycle after that.
- BCD lags `timer` by one cycle.

## Structure
- `passcode_pkg` holds:
  - State encodings `S_IDLE` = 0 through `S_DIG4CORR` = 4, shared with the passcode FSM.
  - Function `is_counting_state`.
  - Default constants `CLK_HZ_DEFAULT` and `TIMEOUT_S_DEFAULT`.
- Sub-module `tick_gen` (parameter `CLK_HZ`; inputs `clear`, `enable`; output `tick`) implements the prescaler and one-second tick.
- The top level holds change detection, the seconds counter, pulse generation and the BCD register.

## Test plan
All scenarios use `CLK_HZ`=10, `TIMEOUT_S`=3.
- Reset: assert `rst_n`=0 mid-count with `passcode_state`=1 -> `timer`=3, `bcd_tens`=0, `bcd_ones`=3, `timeout`=0 asynchronously. The count restarts after release.
- Full countdown: state 0 -> 1 and hold -> `timer` = 3, 2, 1, 0 at 10-cycle spacing. `timeout` is high only in the 0 cycle. `timer` stays 0 and `running`=0 thereafter.
- Reload on digit: state 1 held 15 cycles (`timer`=2), then state 2 -> `timer`=3 next cycle, first decrement 10 cycles later, no `timeout`.
- Holding states: state 4 or 6 for 50 cycles -> `timer` constant 3, `running`=0, no `timeout`.
- Collision: state change on the exact prescaler-wrap cycle -> `timer`=3, no decrement. Change on the cycle `timer` reaches 0 -> single `timeout` pulse, then reload to 3.
- Closed loop with the passcode FSM: enter digit A, then idle 30 cycles -> FSM returns to state 0 on the cycle after `timeout`, and `timer`=3 one cycle later.
